pipe_ctrl: RTL and testbench

//  Pipeline control unit; the receiving end of ex's to-ctrl interface (jump_en/jump_addr/hold_flag).

---
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: turns ex jump/hold requests and the bus-arbiter hold
// into pc_reg redirect, freeze and flush controls for if_id / id_ex.
module pipe_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned FETCH_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic        bus_hold_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o
);

    localparam int unsigned MAXC = (HOLD_CYCLES > FETCH_LAT) ? HOLD_CYCLES : FETCH_LAT;
    localparam int unsigned CW   = (MAXC > 0) ? $clog2(MAXC + 1) : 1;

    localparam logic [CW-1:0] HOLD_INIT  = (HOLD_CYCLES > 1) ? CW'(HOLD_CYCLES - 2) : '0;
    localparam logic [CW-1:0] FLUSH_INIT = (FETCH_LAT > 0)   ? CW'(FETCH_LAT - 1)   : '0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_PEND  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_pend_addr;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [31:0]   w_pend_nxt;

    logic          w_jump_en;
    logic [31:0]   w_jump_addr;
    logic          w_freeze;
    logic          w_hold_pc_only;
    logic          w_flush_if_id;
    logic          w_flush_id_ex;

    // Next-state and raw output decode from current state and inputs
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pend_nxt     = r_pend_addr;
        w_jump_en      = 1'b0;
        w_jump_addr    = '0;
        w_freeze       = 1'b0;
        w_hold_pc_only = 1'b0;
        w_flush_if_id  = 1'b0;
        w_flush_id_ex  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus_hold_i) begin
                    w_freeze = 1'b1;
                    if (jump_en_i) begin
                        w_pend_nxt  = jump_addr_i;
                        w_state_nxt = S_PEND;
                    end
                end else if (jump_en_i) begin
                    w_jump_en     = 1'b1;
                    w_jump_addr   = jump_addr_i;
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                    if (FETCH_LAT > 0) begin
                        w_state_nxt = S_FLUSH;
                        w_cnt_nxt   = FLUSH_INIT;
                    end
                end else if (hold_flag_i) begin
                    w_freeze = 1'b1;
                    if (HOLD_CYCLES > 1) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = HOLD_INIT;
                    end
                end
            end
            S_HOLD: begin
                w_freeze = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_PEND: begin
                if (bus_hold_i) begin
                    w_freeze = 1'b1;
                end else begin
                    w_jump_en     = 1'b1;
                    w_jump_addr   = r_pend_addr;
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                    if (FETCH_LAT > 0) begin
                        w_state_nxt = S_FLUSH;
                        w_cnt_nxt   = FLUSH_INIT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin // S_FLUSH
                w_flush_if_id = 1'b1;
                if (bus_hold_i) begin
                    w_hold_pc_only = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
        endcase
    end

    // State, counter and captured jump target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pend_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pend_addr <= w_pend_nxt;
        end
    end

    // Outputs are forced low while reset is held, whatever the inputs do
    assign jump_en_o     = rst_n & w_jump_en;
    assign jump_addr_o   = rst_n ? w_jump_addr : '0;
    assign hold_pc_o     = rst_n & (w_freeze | w_hold_pc_only);
    assign hold_if_id_o  = rst_n & w_freeze;
    assign hold_id_ex_o  = rst_n & w_freeze;
    assign flush_if_id_o = rst_n & w_flush_if_id;
    assign flush_id_ex_o = rst_n & w_flush_id_ex;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (HOLD_CYCLES=4, FETCH_LAT=1) with an
// expected-output queue filled at drive time and drained at sample time.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        bus_hold_i;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        hold_pc_o;
    logic        hold_if_id_o;
    logic        hold_id_ex_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [37:0] exp_q[$];

    pipe_ctrl #(.HOLD_CYCLES(4), .FETCH_LAT(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .hold_flag_i   (hold_flag_i),
        .bus_hold_i    (bus_hold_i),
        .jump_en_o     (jump_en_o),
        .jump_addr_o   (jump_addr_o),
        .hold_pc_o     (hold_pc_o),
        .hold_if_id_o  (hold_if_id_o),
        .hold_id_ex_o  (hold_id_ex_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o)
    );

    always #5 clk = ~clk;

    // Expected vector {jump_en, addr, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex}
    function automatic logic [37:0] mk(input logic je, input logic [31:0] a, input logic hpc,
                                       input logic hif, input logic hie, input logic fif,
                                       input logic fie);
        return {je, a, hpc, hif, hie, fif, fie};
    endfunction

    function automatic logic [37:0] v_idle();
        return mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [37:0] v_frz();
        return mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic logic [37:0] v_redir(input logic [31:0] a);
        return mk(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endfunction

    function automatic logic [37:0] v_fl(input logic hpc);
        return mk(1'b0, 32'h0, hpc, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    // One cycle: drive inputs after the edge, queue expectation, check at negedge
    task automatic step(input string tag, input logic je, input logic [31:0] a,
                        input logic hf, input logic bh, input logic [37:0] e);
        logic [37:0] got;
        logic [37:0] want;
        jump_en_i   = je;
        jump_addr_i = a;
        hold_flag_i = hf;
        bus_hold_i  = bh;
        exp_q.push_back(e);
        @(negedge clk);
        got  = {jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
                flush_if_id_o, flush_id_ex_o};
        want = exp_q.pop_front();
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        jump_en_i   = 1'b0;
        jump_addr_i = '0;
        hold_flag_i = 1'b0;
        bus_hold_i  = 1'b0;
        @(posedge clk);
        #1;

        // Reset: outputs low even with active requests
        step("rst_idle", 1'b0, 32'h0,   1'b0, 1'b0, v_idle());
        step("rst_jump", 1'b1, 32'h123, 1'b1, 1'b1, v_idle());
        rst_n = 1'b1;
        step("post_rst", 1'b0, 32'h0,   1'b0, 1'b0, v_idle());

        // Plain jump: zero-latency redirect, one extra if_id flush
        step("jmp_redir", 1'b1, 32'h0000_0100, 1'b0, 1'b0, v_redir(32'h100));
        step("jmp_flush", 1'b0, 32'h0,         1'b0, 1'b0, v_fl(1'b0));
        step("jmp_done",  1'b0, 32'h0,         1'b0, 1'b0, v_idle());

        // Hold pulse: exactly four frozen cycles
        step("hp_0", 1'b0, 32'h0, 1'b1, 1'b0, v_frz());
        for (int i = 1; i < 4; i++)
            step("hp_n", 1'b0, 32'h0, 1'b0, 1'b0, v_frz());
        step("hp_end", 1'b0, 32'h0, 1'b0, 1'b0, v_idle());

        // Hold level for 6 cycles: second request starts at cycle 4 and runs to cycle 7
        for (int i = 0; i < 6; i++)
            step("hl_lvl", 1'b0, 32'h0, 1'b1, 1'b0, v_frz());
        step("hl_tail0", 1'b0, 32'h0, 1'b0, 1'b0, v_frz());
        step("hl_tail1", 1'b0, 32'h0, 1'b0, 1'b0, v_frz());
        step("hl_end",   1'b0, 32'h0, 1'b0, 1'b0, v_idle());

        // Jump raised under bus hold is deferred until the bus releases
        step("bh_cap",  1'b1, 32'h0000_0200, 1'b0, 1'b1, v_frz());
        step("bh_ign",  1'b1, 32'h0000_0BAD, 1'b1, 1'b1, v_frz());
        step("bh_2",    1'b0, 32'h0,         1'b0, 1'b1, v_frz());
        step("bh_redir",1'b0, 32'h0,         1'b0, 1'b0, v_redir(32'h200));
        step("bh_flush",1'b0, 32'h0,         1'b0, 1'b0, v_fl(1'b0));
        step("bh_done", 1'b0, 32'h0,         1'b0, 1'b0, v_idle());

        // Bus hold during FLUSH pauses the flush countdown and keeps pc
        step("fb_redir", 1'b1, 32'h0000_0300, 1'b0, 1'b0, v_redir(32'h300));
        step("fb_bh0",   1'b1, 32'h0000_0BAD, 1'b1, 1'b1, v_fl(1'b1));
        step("fb_bh1",   1'b0, 32'h0,         1'b0, 1'b1, v_fl(1'b1));
        step("fb_last",  1'b0, 32'h0,         1'b0, 1'b0, v_fl(1'b0));
        step("fb_done",  1'b0, 32'h0,         1'b0, 1'b0, v_idle());

        // Jump beats hold_flag in IDLE; jump during HOLD is ignored
        step("jh_redir", 1'b1, 32'h0000_0400, 1'b1, 1'b0, v_redir(32'h400));
        step("jh_flush", 1'b0, 32'h0,         1'b0, 1'b0, v_fl(1'b0));
        step("hj_0",     1'b0, 32'h0,         1'b1, 1'b0, v_frz());
        step("hj_jmp",   1'b1, 32'h0000_0500, 1'b0, 1'b0, v_frz());
        step("hj_2",     1'b1, 32'h0000_0500, 1'b1, 1'b0, v_frz());
        step("hj_3",     1'b0, 32'h0,         1'b0, 1'b0, v_frz());
        step("hj_end",   1'b0, 32'h0,         1'b0, 1'b0, v_idle());

        // Reset while a jump is pending discards it
        step("rp_cap", 1'b1, 32'h0000_0600, 1'b0, 1'b1, v_frz());
        step("rp_bh",  1'b0, 32'h0,         1'b0, 1'b1, v_frz());
        rst_n = 1'b0;
        step("rp_rst", 1'b0, 32'h0,         1'b0, 1'b1, v_idle());
        rst_n = 1'b1;
        step("rp_bh2", 1'b0, 32'h0,         1'b0, 1'b1, v_frz());
        step("rp_rel", 1'b0, 32'h0,         1'b0, 1'b0, v_idle());
        step("rp_end", 1'b0, 32'h0,         1'b0, 1'b0, v_idle());

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
